ring_link_arbiter: RTL
======================

Name: ring_link_arbiter

Overview:
- Ring-stop output arbiter. Shares one outgoing ring link between NUM_SRC two-entry source FIFOs: source 0 is ring pass-through, sources 1..NUM_SRC-1 are local injection.
- Issues read-enables to the FIFO heads and registers the granted flit into a single output stage with a valid/ready handshake.
- Pass-through traffic has priority. An anti-starvation counter forces round-robin service of local sources.

Parameters:
- WIDTH, 32, flit width in bits; bit WIDTH-1 is the tail flag.
- NUM_SRC, 2, number of source FIFOs; legal range 2..8.
- STARVE_MAX, 8, consecutive cycles a waiting local source may lose to the ring before it is forced; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- iSrcEmpty  in  NUM_SRC  per-source FIFO empty flag.
- iSrcDat  in  NUM_SRC x WIDTH  per-source FIFO head data.
- oSrcRdEn  out  NUM_SRC  per-source pop; one-hot or zero; combinational.
- oLinkVld  out  1  output flit valid.
- oLinkDat  out  WIDTH  output flit.
- iLinkRdy  in  1  downstream accepts the flit when oLinkVld and iLinkRdy are both high.
- oGrant  out  NUM_SRC  registered one-hot index of the source of the current flit.
- oStarve  out  1  high while the starvation override is active.

Behaviour:
- Reset values: oLinkVld=0, oLinkDat=0, oGrant=0, oStarve=0, starveCnt=0, rrPtr=1, state=S_RING. Reset asserted mid-transfer discards the held flit; no pop occurs while rst is high.
- slotFree = !oLinkVld | iLinkRdy. A pop happens only when slotFree is high and the selected source is non-empty.
- On a pop of source g: oSrcRdEn[g]=1 in that cycle. At the next edge oLinkDat<=iSrcDat[g], oLinkVld<=1, oGrant<=onehot(g).
- Latency: a non-empty head becomes a valid output 1 cycle later. Throughput is 1 flit/cycle while iLinkRdy=1.
- If slotFree is high and nothing is popped: oLinkVld<=0 and oGrant<=0. oLinkDat holds its value.
- If slotFree is low: no pop; all output registers hold.
- FSM states:
  - S_RING: pick source 0 if non-empty, otherwise the round-robin pick among the locals. Go to S_STARVE when starveCnt==STARVE_MAX.
  - S_STARVE: pick the round-robin local only; source 0 waits. oStarve=1. Return to S_RING after the first local pop.
- Round-robin pick: search locals starting at rrPtr and wrap from NUM_SRC-1 back to 1. After a local pop of g, rrPtr<=g+1, wrapping to 1.
- starveCnt:
  - Increments (saturating at STARVE_MAX) in cycles where source 0 is popped while any local is non-empty.
  - Clears on any local pop.
  - Clears when all locals are empty.
  - Holds when slotFree is low.
- Simultaneous transition: if starveCnt reaches STARVE_MAX on the same edge as a ring pop, the next slotFree cycle serves a local.
- All sources empty: no pop; any pending flit drains; the FSM holds its state.

Optional Feature:
- Macro: RING_ARB_PKT_LOCK_EN.
- When defined:
  - A grant made on a non-tail flit (iSrcDat[g][WIDTH-1]=0) locks the arbiter to g until g's tail flit is popped.
  - While locked, no other source is popped. A lock on a local suppresses the starvation FSM; a lock on source 0 defers it.
  - If g goes empty while locked, no pop occurs and the lock holds.
  - Extra output oLocked (1 bit, reset 0) is present.
- When undefined: selection is per-flit; the tail bit is ordinary data; oLocked does not exist.

Decomposition:
- Package ring_arb_pkg:
  - state enum {S_RING, S_STARVE};
  - default WIDTH / NUM_SRC / STARVE_MAX constants;
  - TAIL_BIT constant = WIDTH-1;
  - flit typedef.
- Sub-module ring_rr_pick: combinational picker with inputs request vector and rrPtr, outputs one-hot grant and a valid flag. The top instantiates it once for the local sources.

Test Plan:
1. Ring-only traffic: source 0 holds 4 flits 0xA1..0xA4, locals empty, iLinkRdy=1 -> oLinkVld high for 4 consecutive cycles from cycle 1, data in order, oGrant=01 each cycle.
2. Backpressure: a flit is held with iLinkRdy=0 for 5 cycles -> oSrcRdEn=0, oLinkDat stable; iLinkRdy rises -> pop in that same cycle, next flit valid on the next edge.
3. Starvation, NUM_SRC=2, STARVE_MAX=3: ring always non-empty, local non-empty -> pop sequence ring,ring,ring,local,ring..., oStarve=1 for exactly 1 cycle.
4. Round-robin, NUM_SRC=4, ring empty, locals 1..3 always non-empty -> grants 1,2,3,1,2,3.
5. Reset mid-transfer: rst pulsed asynchronously while oLinkVld=1 -> oLinkVld=0 immediately, and the first grant after release goes to source 0 when it is non-empty.
6. With RING_ARB_PKT_LOCK_EN, NUM_SRC=2: local sends a 3-flit packet (tail flag on the 3rd) while the ring is non-empty -> output is the 3 local flits contiguously, then ring flits; oLocked is high for the 1st and 2nd flits.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared types and defaults for the ring-stop output arbiter.
//   state_t        : arbiter mode (ring priority / forced local service)
//   DEF_*          : default WIDTH / NUM_SRC / STARVE_MAX
//   TAIL_BIT       : tail-flag position for the default flit width
//   flit_t         : default-width flit
package ring_arb_pkg;

    typedef enum logic {
        S_RING,
        S_STARVE
    } state_t;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_NUM_SRC    = 2;
    localparam int unsigned DEF_STARVE_MAX = 8;
    localparam int unsigned TAIL_BIT       = DEF_WIDTH - 1;

    typedef logic [DEF_WIDTH-1:0] flit_t;

endpackage

// File: rtl/ring_link_arbiter_rr_pick.sv
// ring_rr_pick: combinational round-robin picker over the local sources.
//   req : request vector, bit 0 (ring source) is never selected
//   ptr : first local index to consider (1..N-1)
//   gnt : one-hot grant, zero when no local requests
//   vld : a local was selected
module ring_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    localparam int unsigned EW = PW + 1;
    localparam logic [PW:0] N_EXT    = EW'(N);
    localparam logic [PW:0] WRAP_SUB = EW'(N - 1);

    logic [PW:0] cand;

    // Walk N-1 candidates from ptr; indices past N-1 fold back onto 1..N-1.
    always_comb begin
        gnt  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N - 1; k++) begin
            cand = {1'b0, ptr} + EW'(k);
            if (cand >= N_EXT) begin
                cand = cand - WRAP_SUB;
            end
            if (!vld && req[cand[PW-1:0]]) begin
                gnt[cand[PW-1:0]] = 1'b1;
                vld               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_link_arbiter.sv
// ring_link_arbiter: shares one outgoing ring link between NUM_SRC source
// FIFOs. Source 0 is ring pass-through (priority), 1..NUM_SRC-1 are local
// injection served round-robin; a starvation counter forces local service.
//   clk, rst   : clock, asynchronous active-high reset
//   iSrcEmpty  : per-source FIFO empty flags
//   iSrcDat    : per-source FIFO head flits
//   oSrcRdEn   : per-source pop (one-hot or zero, combinational)
//   oLinkVld   : output flit valid
//   oLinkDat   : output flit
//   iLinkRdy   : downstream ready
//   oGrant     : one-hot source of the current output flit
//   oStarve    : forced-local mode active
//   oLocked    : packet lock active (only with RING_ARB_PKT_LOCK_EN)
// Optional feature macro: RING_ARB_PKT_LOCK_EN (packet lock on non-tail flits).
module ring_link_arbiter
    import ring_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            iSrcEmpty,
    input  logic [NUM_SRC-1:0][WIDTH-1:0] iSrcDat,
    output logic [NUM_SRC-1:0]            oSrcRdEn,
    output logic                          oLinkVld,
    output logic [WIDTH-1:0]              oLinkDat,
    input  logic                          iLinkRdy,
    output logic [NUM_SRC-1:0]            oGrant,
    output logic                          oStarve
`ifdef RING_ARB_PKT_LOCK_EN
    ,
    output logic                          oLocked
`endif
);

    localparam int unsigned PW   = $clog2(NUM_SRC);
    localparam int unsigned CW   = $clog2(STARVE_MAX + 1);
    localparam int unsigned TAIL = WIDTH - 1;
    localparam logic [CW-1:0]      CNT_MAX     = CW'(STARVE_MAX);
    localparam logic [PW-1:0]      LAST_SRC    = PW'(NUM_SRC - 1);
    localparam logic [PW-1:0]      FIRST_LOC   = PW'(1);
    localparam logic [NUM_SRC-1:0] LOCAL_MASK  = {{(NUM_SRC-1){1'b1}}, 1'b0};
    localparam logic [NUM_SRC-1:0] RING_ONEHOT = NUM_SRC'(1);

    state_t             state, state_nxt;
    logic [CW-1:0]      starve_cnt, cnt_nxt;
    logic [PW-1:0]      rr_ptr, pop_idx;
    logic [NUM_SRC-1:0] local_req, rr_gnt, fsm_sel, sel, pop;
    logic               rr_vld, slot_free, local_pop, ring_pop, any_local;

    assign slot_free = !oLinkVld || iLinkRdy;
    assign local_req = ~iSrcEmpty & LOCAL_MASK;
    assign any_local = |local_req;

    ring_rr_pick #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_rr_pick (
        .req (local_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .vld (rr_vld)
    );

    always_comb begin
        fsm_sel = rr_vld ? rr_gnt : '0;
        if (state == S_RING && !iSrcEmpty[0]) begin
            fsm_sel = RING_ONEHOT;
        end
    end

`ifdef RING_ARB_PKT_LOCK_EN
    logic               locked;
    logic [NUM_SRC-1:0] lock_src;

    // A held lock overrides the FSM choice; the FSM keeps running so a
    // ring lock only defers a pending starvation override.
    assign sel     = locked ? lock_src : fsm_sel;
    assign oLocked = locked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_src <= '0;
        end else if (|pop) begin
            locked   <= !iSrcDat[pop_idx][TAIL];
            lock_src <= pop;
        end
    end
`else
    assign sel = fsm_sel;
`endif

    assign pop       = (slot_free && !rst) ? (sel & ~iSrcEmpty) : '0;
    assign ring_pop  = pop[0];
    assign local_pop = |(pop & LOCAL_MASK);

    always_comb begin
        pop_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pop[i]) begin
                pop_idx = PW'(i);
            end
        end
    end

    always_comb begin
        cnt_nxt = starve_cnt;
        if (slot_free) begin
            if (local_pop || !any_local) begin
                cnt_nxt = '0;
            end else if (ring_pop && starve_cnt != CNT_MAX) begin
                cnt_nxt = starve_cnt + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RING;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state; compares the post-edge count so the saturating ring
    // pop itself hands the very next slot to a local.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RING:   if (cnt_nxt == CNT_MAX) state_nxt = S_STARVE;
            S_STARVE: if (local_pop)          state_nxt = S_RING;
            default:  state_nxt = S_RING;
        endcase
    end

    // FSM: outputs
    always_comb begin
        oStarve  = (state == S_STARVE);
        oSrcRdEn = pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            rr_ptr     <= FIRST_LOC;
        end else begin
            starve_cnt <= cnt_nxt;
            if (local_pop) begin
                rr_ptr <= (pop_idx == LAST_SRC) ? FIRST_LOC : pop_idx + FIRST_LOC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oLinkVld <= 1'b0;
            oLinkDat <= '0;
            oGrant   <= '0;
        end else if (slot_free) begin
            if (|pop) begin
                oLinkVld <= 1'b1;
                oLinkDat <= iSrcDat[pop_idx];
                oGrant   <= pop;
            end else begin
                oLinkVld <= 1'b0;
                oGrant   <= '0;
            end
        end
    end

endmodule
